sw_seq_feeder: RTL

- Transmit-side companion to the Smith-Waterman core's serial sequence input.
- Holds query (S) and database (T) symbol buffers loaded by a host port.
- On start, streams both sequences symbol-per-cycle on the core's valid/data_s/data_t interface.
- Waits for the core's finish, captures its 12-bit max score, and reports the result to the host with a done pulse and a timeout guard.

---
 rtl/sw_seq_feeder_if.sv | 11 +
 rtl/sw_seq_feeder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sw_seq_feeder_if.sv
// Symbol-stream link between the sequence feeder (master) and the Smith-Waterman core (slave).
interface sw_seq_feeder_if;
    logic        sw_valid;
    logic [1:0]  sw_data_s;
    logic [1:0]  sw_data_t;
    logic        sw_finish;
    logic [11:0] sw_max;

    modport master (output sw_valid, sw_data_s, sw_data_t, input sw_finish, sw_max);
    modport slave  (input sw_valid, sw_data_s, sw_data_t, output sw_finish, sw_max);
endinterface

// File: rtl/sw_seq_feeder.sv
// Streams host-loaded S/T buffers to the SW core, then captures its max score or times out.
// Optional running checksum of streamed symbols via SW_FEEDER_CHECKSUM_EN (stream_sum_o).
module sw_seq_feeder #(
    parameter int LEN         = 64,
    parameter int ADDR_W      = 6,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [1:0]        ld_s_i,
    input  logic [1:0]        ld_t_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [11:0]       result_max_o,
    output logic              timeout_o,
`ifdef SW_FEEDER_CHECKSUM_EN
    output logic [7:0]        stream_sum_o,
`endif
    sw_seq_feeder_if.master   core
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_DONE} state_t;

    localparam logic [ADDR_W:0] IDX_END = (ADDR_W+1)'(LEN);
    localparam logic [11:0]     TO_END  = 12'(TIMEOUT_CYC);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [11:0]       cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [1:0]        ds_q, ds_d;
    logic [1:0]        dt_q, dt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [11:0]       res_q, res_d;
    logic              to_q, to_d;
`ifdef SW_FEEDER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic [1:0] mem_s_q [LEN];
    logic [1:0] mem_t_q [LEN];

    // Buffer is only writable while idle, so a run always sees a frozen snapshot.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && ld_we_i) begin
            mem_s_q[ld_addr_i] <= ld_s_i;
            mem_t_q[ld_addr_i] <= ld_t_i;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ds_d    = ds_q;
        dt_d    = dt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        res_d   = res_q;
        to_d    = to_q;
`ifdef SW_FEEDER_CHECKSUM_EN
        sum_d   = valid_q ? sum_q + {4'b0000, ds_q, dt_q} : sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i && !ld_we_i) begin
                    state_d = S_STREAM;
                    valid_d = 1'b1;
                    ds_d    = mem_s_q[0];
                    dt_d    = mem_t_q[0];
                    idx_d   = (ADDR_W+1)'(1);
                    busy_d  = 1'b1;
`ifdef SW_FEEDER_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                end
            end
            S_STREAM: begin
                if (idx_q == IDX_END) begin
                    state_d = S_WAIT;
                    valid_d = 1'b0;
                    ds_d    = 2'd0;
                    dt_d    = 2'd0;
                    cnt_d   = 12'd0;
                end else begin
                    ds_d  = mem_s_q[idx_q[ADDR_W-1:0]];
                    dt_d  = mem_t_q[idx_q[ADDR_W-1:0]];
                    idx_d = idx_q + 1'b1;
                end
            end
            S_WAIT: begin
                // Finish takes priority over a coincident timeout.
                if (core.sw_finish) begin
                    state_d = S_DONE;
                    res_d   = core.sw_max;
                    to_d    = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (cnt_q + 12'd1 == TO_END) begin
                    state_d = S_DONE;
                    res_d   = 12'd0;
                    to_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ds_q    <= 2'd0;
            dt_q    <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= 12'd0;
            to_q    <= 1'b0;
`ifdef SW_FEEDER_CHECKSUM_EN
            sum_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ds_q    <= ds_d;
            dt_q    <= dt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
            to_q    <= to_d;
`ifdef SW_FEEDER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign core.sw_valid  = valid_q;
    assign core.sw_data_s = ds_q;
    assign core.sw_data_t = dt_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign result_max_o   = res_q;
    assign timeout_o      = to_q;
`ifdef SW_FEEDER_CHECKSUM_EN
    assign stream_sum_o   = sum_q;
`endif

endmodule
